muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/riscy_pkg.sv | 18 +
 rtl/muldiv_unit.sv | 110 +++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/riscy_pkg.sv
// riscy_pkg: op encodings, muldiv FSM states and operand-sign helpers shared by decode, cpu and muldiv_unit.
package riscy_pkg;

    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } muldiv_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} muldiv_state_e;

    function automatic logic op_x_signed(input logic [2:0] op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_y_signed(input logic [2:0] op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply (shift-add) and restoring divide, one bit per cycle,
// with single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit
    import riscy_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);

    localparam int W2 = 2 * XLEN;

    muldiv_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]    acc, acc_nxt, b, x_ext;
    logic [XLEN-1:0]  m, out_r, x_mag, y_mag, fast_val, fin, q, r;
    logic [XLEN:0]    diff;
    logic [2:0]       op_r;
    logic             neg_q, neg_r, accept, fast, x_sgn, y_sgn, last;

    assign in_ready  = reset_n && state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign out       = out_r;
    assign accept    = in_valid && in_ready && !flush;
    assign last      = cnt == CNT_W'(1);

    assign x_sgn = op_x_signed(op) && x[XLEN-1];
    assign y_sgn = op_y_signed(op) && y[XLEN-1];
    assign x_ext = {{XLEN{x_sgn}}, x};
    assign x_mag = x_sgn ? -x : x;
    assign y_mag = y_sgn ? -y : y;

    assign fast = op[2] && (y == '0 || (!op[0] && x == {1'b1, {(XLEN-1){1'b0}}} && y == '1));
    assign fast_val = y == '0 ? (op[1] ? x : '1) : (op[1] ? '0 : x);

    // Divide keeps {remainder, dividend/quotient} in acc; the top bit shifted out joins the trial subtract.
    assign diff = acc[W2-1:XLEN-1] - {1'b0, b[XLEN-1:0]};
    assign acc_nxt = op_r[2] ? (diff[XLEN] ? {acc[W2-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                             : (m[0] ? acc + b : acc);
    assign q = acc_nxt[XLEN-1:0];
    assign r = acc_nxt[W2-1:XLEN];
    assign fin = !op_r[2] ? (op_r[1:0] == 2'b00 ? q : r)
               : op_r[1]  ? (neg_r ? -r : r)
               :            (neg_q ? -q : q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = fast ? ST_DONE : ST_BUSY;
            ST_BUSY: if (last) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            acc   <= '0;
            b     <= '0;
            m     <= '0;
            op_r  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            out_r <= '0;
        end else if (accept) begin
            op_r  <= op;
            neg_q <= x_sgn ^ y_sgn;
            neg_r <= x_sgn;
            cnt   <= fast ? '0 : CNT_W'(XLEN);
            if (fast) out_r <= fast_val;
            if (op[2]) begin
                acc <= {{XLEN{1'b0}}, x_mag};
                b   <= {{XLEN{1'b0}}, y_mag};
                m   <= '0;
            end else begin
                // Only the low XLEN multiplier bits are iterated; a negative signed y is corrected up front.
                acc <= y_sgn ? -(x_ext << XLEN) : '0;
                b   <= x_ext;
                m   <= y;
            end
        end else if (state == ST_BUSY) begin
            acc <= acc_nxt;
            b   <= op_r[2] ? b : {b[W2-2:0], 1'b0};
            m   <= m >> 1;
            cnt <= cnt - 1'b1;
            if (last) out_r <= fin;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic            in_ready, out_valid;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] x = '0, y = '0, out;
    int              n_checks = 0, n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .x(x), .y(y), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        longint sa, sd, ua, ud;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sd  = longint'($signed(d));
        ua  = longint'({32'b0, a});
        ud  = longint'({32'b0, d});
        ovf = a == 32'h8000_0000 && d == 32'hFFFF_FFFF;
        case (o)
            3'd0: begin p = 64'(ua * ud); return p[31:0]; end
            3'd1: begin p = 64'(sa * sd); return p[63:32]; end
            3'd2: begin p = 64'(sa * ud); return p[63:32]; end
            3'd3: begin p = 64'(ua * ud); return p[63:32]; end
            3'd4: return d == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sd);
            3'd5: return d == 0 ? 32'hFFFF_FFFF : a / d;
            3'd6: return d == 0 ? a : ovf ? 32'h0 : 32'(sa % sd);
            default: return d == 0 ? a : a % d;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        if (o[2] && (d == 0 || (o inside {3'd4, 3'd6} && a == 32'h8000_0000 && d == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        op = o; x = a; y = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); x = $urandom; y = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("timeout out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic take();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready after take", 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        int lat;
        start(o, a, d);
        wait_done(lat);
        check({tag, " out"}, out, model(o, a, d));
        check({tag, " lat"}, 32'(lat), 32'(model_lat(o, a, d)));
        take();
    endtask

    task automatic no_valid(input string tag, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int lat;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out", out, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset", 32'(in_ready), 32'd1);

        run("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        check("MUL 7*-3 literal", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        run("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2);
        run("DIV -7/2", 3'd4, -32'd7, 32'd2);
        run("REM -7%2", 3'd6, -32'd7, 32'd2);
        run("DIVU 100/7", 3'd5, 32'd100, 32'd7);
        run("REMU 100%7", 3'd7, 32'd100, 32'd7);
        run("DIVU 5/0", 3'd5, 32'd5, 32'd0);
        run("REM 5/0", 3'd6, 32'd5, 32'd0);
        run("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        start(3'd0, 32'd7, 32'hFFFF_FFFD);
        wait_done(lat);
        repeat (5) begin
            check("stall out", out, 32'hFFFF_FFEB);
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall release in_ready", 32'(in_ready), 32'd1);
        check("stall release out_valid", 32'(out_valid), 32'd0);

        start(3'd4, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy in_ready", 32'(in_ready), 32'd1);
        no_valid("flush busy no out_valid", 40);

        in_valid = 1'b1; flush = 1'b1; op = 3'd0; x = 32'd3; y = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush+in_valid in_ready", 32'(in_ready), 32'd1);
        no_valid("flush+in_valid no out_valid", 40);

        start(3'd5, 32'd9, 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush done out_valid", 32'(out_valid), 32'd0);
        check("flush done in_ready", 32'(in_ready), 32'd1);

        start(3'd0, 32'd12345, 32'd678);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid reset in_ready", 32'(in_ready), 32'd0);
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset out", out, 32'd0);
        @(posedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;
        check("post reset in_ready", 32'(in_ready), 32'd1);
        no_valid("post reset no out_valid", 40);

        for (int i = 0; i < 200; i++) begin
            logic [2:0] o;
            o = 3'($urandom);
            run($sformatf("rand%0d op%0d", i, o), o, pick(), pick());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
